cfg_frame_loader: RTL

Serial configuration loader for the eFPGA programming domain. It receives a bitstream on the programming clock, assembles it into fixed-width frames with per-frame parity, stages all frames, and commits them atomically to the `prog` configuration ports of the logic modules directly downstream. A partially loaded, aborted or corrupted bitstream never reaches the fabric.

---
 rtl/efpga_cfg_pkg.sv | 21 ++
 rtl/cfg_frame_loader_if.sv | 36 +++
 rtl/cfg_frame_shifter.sv | 48 ++++
 rtl/cfg_frame_loader.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/efpga_cfg_pkg.sv
// Shared types and helpers for the eFPGA configuration loader.
// Frame width default, loader states and the parity check.
package efpga_cfg_pkg;

    localparam int CFG_FRAME_W = 34;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PARITY,
        COMMIT,
        DONE,
        ERROR
    } cfg_state_e;

    // data is the running XOR of a frame; pbit is its parity bit
    function automatic logic even_par(input logic data, input logic pbit);
        return ~(data ^ pbit);
    endfunction

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Serial programming bundle between a bitstream source and the loader.
// The source drives start/data/valid; the loader reports its status.
interface cfg_frame_loader_if #(
    parameter int N_FRAMES = 4,
    parameter int IDX_W    = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1
);

    logic             prog_start;
    logic             prog_sdi;
    logic             prog_valid;
    logic             prog_busy;
    logic             prog_done;
    logic             prog_err;
    logic [IDX_W-1:0] prog_frame;

    modport master (
        output prog_start,
        output prog_sdi,
        output prog_valid,
        input  prog_busy,
        input  prog_done,
        input  prog_err,
        input  prog_frame
    );

    modport slave (
        input  prog_start,
        input  prog_sdi,
        input  prog_valid,
        output prog_busy,
        output prog_done,
        output prog_err,
        output prog_frame
    );

endinterface

// File: rtl/cfg_frame_shifter.sv
// Frame assembler: shift register, data bit counter and running parity.
// The controller decides when a bit is data, parity, or discarded.
module cfg_frame_shifter
    import efpga_cfg_pkg::*;
#(
    parameter int FRAME_W = CFG_FRAME_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               par_en,
    input  logic               sdi,
    output logic               frame_full,
    output logic [FRAME_W-1:0] frame,
    output logic               par_ok
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (clear) begin
            bit_cnt <= '0;
            par     <= 1'b0;
        end else if (shift_en) begin
            shreg   <= {shreg[FRAME_W-2:0], sdi};
            par     <= par ^ sdi;
            bit_cnt <= bit_cnt + CNT_W'(1);
        end else if (par_en && par_ok) begin
            // frame accepted: ready for the next one
            bit_cnt <= '0;
            par     <= 1'b0;
        end
    end

    assign frame_full = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign frame      = shreg;
    assign par_ok     = even_par(par, sdi);

endmodule

// File: rtl/cfg_frame_loader.sv
// Serial configuration loader: assembles parity-checked frames,
// stages them, and commits the whole set atomically to cfg_out.
module cfg_frame_loader
    import efpga_cfg_pkg::*;
#(
    parameter int FRAME_W  = CFG_FRAME_W,
    parameter int N_FRAMES = 4
) (
    input  logic                        prog_clk,
    input  logic                        prog_nres,
    cfg_frame_loader_if.slave           prog,
    output logic [N_FRAMES*FRAME_W-1:0] cfg_out
);

    localparam int IDX_W = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;

    cfg_state_e         state_q;
    cfg_state_e         state_d;
    logic [IDX_W-1:0]   frame_q;
    logic               done_q;
    logic               err_q;
    logic [FRAME_W-1:0] staging [N_FRAMES];
    logic [N_FRAMES*FRAME_W-1:0] staged_flat;

    logic               shift_en;
    logic               par_en;
    logic               stage_en;
    logic               frame_inc;
    logic               set_err;
    logic               commit;

    logic               frame_full;
    logic [FRAME_W-1:0] frame;
    logic               par_ok;
    logic               last_frame;

    cfg_frame_shifter #(
        .FRAME_W(FRAME_W)
    ) u_shifter (
        .clk       (prog_clk),
        .rst_n     (prog_nres),
        .clear     (prog.prog_start),
        .shift_en  (shift_en),
        .par_en    (par_en),
        .sdi       (prog.prog_sdi),
        .frame_full(frame_full),
        .frame     (frame),
        .par_ok    (par_ok)
    );

    assign last_frame = (frame_q == IDX_W'(N_FRAMES - 1));

    always_ff @(posedge prog_clk or negedge prog_nres) begin
        if (!prog_nres) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stage_en  = 1'b0;
        frame_inc = 1'b0;
        set_err   = 1'b0;
        commit    = 1'b0;
        // a start pulse overrides everything, including a same-cycle bit
        if (prog.prog_start) begin
            state_d = SHIFT;
        end else begin
            unique case (state_q)
                SHIFT: begin
                    if (prog.prog_valid) begin
                        shift_en = 1'b1;
                        if (frame_full) state_d = PARITY;
                    end
                end
                PARITY: begin
                    if (prog.prog_valid) begin
                        par_en = 1'b1;
                        if (par_ok) begin
                            stage_en = 1'b1;
                            if (last_frame) begin
                                state_d = COMMIT;
                            end else begin
                                frame_inc = 1'b1;
                                state_d   = SHIFT;
                            end
                        end else begin
                            set_err = 1'b1;
                            state_d = ERROR;
                        end
                    end
                end
                COMMIT: begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
                IDLE, DONE, ERROR: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        staged_flat = '0;
        for (int f = 0; f < N_FRAMES; f++) begin
            staged_flat[f*FRAME_W +: FRAME_W] = staging[f];
        end
    end

    always_ff @(posedge prog_clk or negedge prog_nres) begin
        if (!prog_nres) begin
            frame_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cfg_out <= '0;
            for (int f = 0; f < N_FRAMES; f++) begin
                staging[f] <= '0;
            end
        end else if (prog.prog_start) begin
            frame_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (stage_en) staging[frame_q] <= frame;
            if (frame_inc) frame_q <= frame_q + IDX_W'(1);
            if (set_err) err_q <= 1'b1;
            if (commit) begin
                cfg_out <= staged_flat;
                done_q  <= 1'b1;
            end
        end
    end

    assign prog.prog_busy  = (state_q == SHIFT) ||
                             (state_q == PARITY) ||
                             (state_q == COMMIT);
    assign prog.prog_done  = done_q;
    assign prog.prog_err   = err_q;
    assign prog.prog_frame = frame_q;

endmodule
